// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the SDRAM CPU/data command port between the boot loader, the Z80
//   memory interface and an auxiliary DMA port. Only one transaction is in
//   flight at a time. The command fields are held stable until the SDRAM core
//   acknowledges. Completion is reported with a one-cycle ack pulse.
//
//   Build option: define MEM_ARB_AUX_EN to arbitrate the aux port
//   (round-robin against the CPU). When it is undefined, aux is ignored,
//   aux_ack is 0 and aux_dout is 8'hFF.
//
//   Parameter: TIMEOUT (16..255) - watchdog limit in WAIT before abort.
//
//   Ports:
//     clk_sys, reset         system clock, synchronous active-high reset
//     boot_mode              ROM download active, blocks CPU/aux grants
//     boot_wr/addr/bank/din  boot write strobe and fields (1-entry buffer)
//     cpu_req/we/addr/bank/din, cpu_dout, cpu_ack   Z80 request port
//     aux_req/we/addr/din, aux_dout, aux_ack        DMA request port (bank 0)
//     mem_req/we/addr/bank/din, mem_dout, mem_ack   SDRAM core command port
//     boot_ovf               sticky: boot strobe dropped, buffer was full
//     timeout_err            sticky: a transaction was aborted by watchdog
module mem_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        boot_mode,
   input  logic        boot_wr,
   input  logic [22:0] boot_addr,
   input  logic [1:0]  boot_bank,
   input  logic [7:0]  boot_din,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [22:0] cpu_addr,
   input  logic [1:0]  cpu_bank,
   input  logic [7:0]  cpu_din,
   output logic [7:0]  cpu_dout,
   output logic        cpu_ack,
   input  logic        aux_req,
   input  logic        aux_we,
   input  logic [22:0] aux_addr,
   input  logic [7:0]  aux_din,
   output logic [7:0]  aux_dout,
   output logic        aux_ack,
   output logic        mem_req,
   output logic        mem_we,
   output logic [22:0] mem_addr,
   output logic [1:0]  mem_bank,
   output logic [7:0]  mem_din,
   input  logic [7:0]  mem_dout,
   input  logic        mem_ack,
   output logic        boot_ovf,
   output logic        timeout_err
);

   typedef enum logic [1:0] {IDLE, WAIT, ACK, GAP} state_t;
   typedef enum logic [1:0] {OWN_BOOT, OWN_CPU, OWN_AUX} owner_t;

   localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);

   state_t      state, state_next;
   owner_t      owner;
   logic        boot_valid;
   logic [22:0] boot_addr_q;
   logic [1:0]  boot_bank_q;
   logic [7:0]  boot_din_q;
   logic [7:0]  wd_cnt;
   logic        grant_boot, grant_cpu, grant_aux;
   logic        done_ok, done_to, done;
   logic [7:0]  rd_data;

`ifdef MEM_ARB_AUX_EN
   logic        last_aux;   // 1: aux was served last, CPU wins the next tie
`endif

   always_ff @(posedge clk_sys) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      grant_boot = 1'b0;
      grant_cpu  = 1'b0;
      grant_aux  = 1'b0;
      done_ok    = 1'b0;
      done_to    = 1'b0;
      cpu_ack    = 1'b0;
`ifdef MEM_ARB_AUX_EN
      aux_ack    = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (boot_valid) begin
               grant_boot = 1'b1;
            end else if (!boot_mode) begin
`ifdef MEM_ARB_AUX_EN
               if (aux_req && (!cpu_req || !last_aux)) grant_aux = 1'b1;
               else if (cpu_req)                       grant_cpu = 1'b1;
`else
               grant_cpu = cpu_req;
`endif
            end
            if (grant_boot || grant_cpu || grant_aux) state_next = WAIT;
         end
         WAIT: begin
            if (mem_ack) begin
               done_ok    = 1'b1;
               state_next = ACK;
            end else if (wd_cnt == WD_LIMIT) begin
               done_to    = 1'b1;
               state_next = ACK;
            end
         end
         ACK: begin
            cpu_ack    = (owner == OWN_CPU);
`ifdef MEM_ARB_AUX_EN
            aux_ack    = (owner == OWN_AUX);
`endif
            state_next = GAP;
         end
         GAP:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign done    = done_ok | done_to;
   assign rd_data = done_ok ? mem_dout : 8'hFF;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         owner       <= OWN_BOOT;
         boot_valid  <= 1'b0;
         boot_addr_q <= '0;
         boot_bank_q <= '0;
         boot_din_q  <= '0;
         wd_cnt      <= '0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_bank    <= '0;
         mem_din     <= '0;
         cpu_dout    <= 8'hFF;
         boot_ovf    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         mem_req <= 1'b0;

         // A granted boot entry still occupies the buffer until ACK, so a
         // strobe arriving meanwhile counts as an overflow.
         if (boot_wr) begin
            if (boot_valid) begin
               boot_ovf <= 1'b1;
            end else begin
               boot_valid  <= 1'b1;
               boot_addr_q <= boot_addr;
               boot_bank_q <= boot_bank;
               boot_din_q  <= boot_din;
            end
         end

         if (grant_boot) begin
            owner    <= OWN_BOOT;
            mem_we   <= 1'b1;
            mem_addr <= boot_addr_q;
            mem_bank <= boot_bank_q;
            mem_din  <= boot_din_q;
         end
         if (grant_cpu) begin
            owner    <= OWN_CPU;
            mem_we   <= cpu_we;
            mem_addr <= cpu_addr;
            mem_bank <= cpu_bank;
            mem_din  <= cpu_din;
         end
`ifdef MEM_ARB_AUX_EN
         if (grant_aux) begin
            owner    <= OWN_AUX;
            mem_we   <= aux_we;
            mem_addr <= aux_addr;
            mem_bank <= 2'b00;
            mem_din  <= aux_din;
         end
`endif
         if (grant_boot || grant_cpu || grant_aux) begin
            mem_req <= 1'b1;
            wd_cnt  <= '0;
         end

         // The watchdog holds at 0 during the strobe cycle, so an abort ack
         // lands TIMEOUT+2 cycles after mem_req.
         if (state == WAIT && !mem_req) wd_cnt <= wd_cnt + 8'd1;

         if (done_to) timeout_err <= 1'b1;
         if (done && !mem_we && owner == OWN_CPU) cpu_dout <= rd_data;
         if (done && owner == OWN_BOOT) boot_valid <= 1'b0;
      end
   end

`ifdef MEM_ARB_AUX_EN
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         last_aux <= 1'b1;
         aux_dout <= 8'hFF;
      end else begin
         if (grant_aux)      last_aux <= 1'b1;
         else if (grant_cpu) last_aux <= 1'b0;
         if (done && !mem_we && owner == OWN_AUX) aux_dout <= rd_data;
      end
   end
`else
   logic unused_aux;
   assign unused_aux = ^{aux_req, aux_we, aux_addr, aux_din};
   assign aux_ack    = 1'b0;
   assign aux_dout   = 8'hFF;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int unsigned TO = 20;
`ifdef MEM_ARB_AUX_EN
   localparam bit AUX_EN = 1'b1;
`else
   localparam bit AUX_EN = 1'b0;
`endif

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        boot_mode, boot_wr;
   logic [22:0] boot_addr;
   logic [1:0]  boot_bank;
   logic [7:0]  boot_din;
   logic        cpu_req, cpu_we;
   logic [22:0] cpu_addr;
   logic [1:0]  cpu_bank;
   logic [7:0]  cpu_din, cpu_dout;
   logic        cpu_ack;
   logic        aux_req, aux_we;
   logic [22:0] aux_addr;
   logic [7:0]  aux_din, aux_dout;
   logic        aux_ack;
   logic        mem_req, mem_we;
   logic [22:0] mem_addr;
   logic [1:0]  mem_bank;
   logic [7:0]  mem_din, mem_dout;
   logic        mem_ack;
   logic        boot_ovf, timeout_err;

   always #8 clk_sys = ~clk_sys;

   mem_arbiter #(.TIMEOUT(TO)) dut (
      .clk_sys(clk_sys), .reset(reset),
      .boot_mode(boot_mode), .boot_wr(boot_wr), .boot_addr(boot_addr),
      .boot_bank(boot_bank), .boot_din(boot_din),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_bank(cpu_bank), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
      .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
      .aux_din(aux_din), .aux_dout(aux_dout), .aux_ack(aux_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_bank(mem_bank),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_ack(mem_ack),
      .boot_ovf(boot_ovf), .timeout_err(timeout_err)
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned cyc = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // Reference memory contents as the bench intends them; unwritten cells
   // read a fixed address-derived pattern shared with the SDRAM model.
   logic [7:0] ref_mem [logic [24:0]];
   logic [7:0] sd_arr  [logic [24:0]];
   logic [7:0] exp_cpu_dout = 8'hFF;

   function automatic logic [7:0] dflt(input logic [24:0] k);
      return k[7:0] ^ 8'h3C;
   endfunction

   function automatic logic [7:0] ref_rd(input logic [24:0] k);
      return ref_mem.exists(k) ? ref_mem[k] : dflt(k);
   endfunction

   // SDRAM core model: logs every command, acks sd_lat cycles after mem_req
   // (sd_lat == 0 means never), counts ack pulses seen from the arbiter.
   typedef struct {
      logic        we;
      logic [22:0] addr;
      logic [1:0]  bank;
      logic [7:0]  din;
      int unsigned cyc;
   } cmd_t;
   cmd_t        cmd_q[$];
   cmd_t        ent;
   int unsigned sd_lat = 1;
   int unsigned sd_cnt = 0;
   logic [24:0] pend_key;
   logic        pend_we;
   int unsigned cpu_acks = 0;
   int unsigned aux_acks = 0;

   initial begin
      mem_ack  = 1'b0;
      mem_dout = 8'h00;
      forever begin
         @(negedge clk_sys);
         mem_ack = 1'b0;
         if (cpu_ack) cpu_acks++;
         if (aux_ack) aux_acks++;
         if (sd_cnt != 0) begin
            sd_cnt--;
            if (sd_cnt == 0) begin
               mem_ack  = 1'b1;
               mem_dout = pend_we ? 8'($urandom)
                        : (sd_arr.exists(pend_key) ? sd_arr[pend_key] : dflt(pend_key));
            end
         end
         if (mem_req) begin
            ent.we = mem_we; ent.addr = mem_addr; ent.bank = mem_bank;
            ent.din = mem_din; ent.cyc = cyc;
            cmd_q.push_back(ent);
            pend_key = {mem_bank, mem_addr};
            pend_we  = mem_we;
            if (mem_we) sd_arr[pend_key] = mem_din;
            sd_cnt = sd_lat;
         end
      end
   end

   // One CPU transaction: request, wait (bounded) for cpu_ack, drop req on
   // the edge after ack, then check the command, timing and returned data.
   task automatic cpu_access(input logic we, input logic [22:0] a, input logic [1:0] b,
                             input logic [7:0] d, input int unsigned lat);
      int unsigned c0, ack_c, exp_ack;
      bit          got;
      cmd_t        c;
      cmd_q.delete();
      sd_lat   = lat;
      cpu_we   = we; cpu_addr = a; cpu_bank = b; cpu_din = d;
      cpu_req  = 1'b1;
      c0    = cyc;
      ack_c = 0;
      got   = 1'b0;
      for (int i = 0; i < int'(TO) + 40 && !got; i++) begin
         tick();
         if (cpu_ack) begin
            got   = 1'b1;
            ack_c = cyc;
         end
      end
      check("cpu_ack_seen", 32'(got), 32'd1);
      tick();
      cpu_req = 1'b0;
      repeat (2) tick();
      check("cmd_count", 32'(cmd_q.size()), 32'd1);
      if (cmd_q.size() != 0) begin
         c = cmd_q[0];
         check("req_latency", c.cyc, c0 + 1);
         check("cmd_we", 32'(c.we), 32'(we));
         check("cmd_addr", 32'(c.addr), 32'(a));
         check("cmd_bank", 32'(c.bank), 32'(b));
         if (we) check("cmd_din", 32'(c.din), 32'(d));
         exp_ack = (lat == 0) ? c.cyc + TO + 2 : c.cyc + lat + 1;
         check("ack_time", ack_c, exp_ack);
      end
      if (!we) exp_cpu_dout = (lat == 0) ? 8'hFF : ref_rd({b, a});
      else     ref_mem[{b, a}] = d;
      check("cpu_dout", 32'(cpu_dout), 32'(exp_cpu_dout));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not reach its end");
      $fatal(1);
   end

   logic [1:0]  bb [4];
   int unsigned bc [4];
   int unsigned c0, bcpu, baux, lat;
   logic        rwe;
   logic [22:0] ra;
   logic [1:0]  rb;
   logic [7:0]  rd;
   cmd_t        c;

   initial begin
      reset = 1'b1; boot_mode = 1'b0; boot_wr = 1'b0;
      boot_addr = '0; boot_bank = '0; boot_din = '0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_bank = '0; cpu_din = '0;
      aux_req = 1'b0; aux_we = 1'b0; aux_addr = '0; aux_din = '0;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      // Reset state
      check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
      check("rst_aux_ack", 32'(aux_ack), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_bank", 32'(mem_bank), 32'd0);
      check("rst_mem_din", 32'(mem_din), 32'd0);
      check("rst_cpu_dout", 32'(cpu_dout), 32'hFF);
      check("rst_aux_dout", 32'(aux_dout), 32'hFF);
      check("rst_boot_ovf", 32'(boot_ovf), 32'd0);
      check("rst_timeout_err", 32'(timeout_err), 32'd0);

      // Single CPU read, SDRAM acks after 5 cycles with 5A
      sd_arr[{2'b00, 23'h000123}]  = 8'h5A;
      ref_mem[{2'b00, 23'h000123}] = 8'h5A;
      cpu_access(1'b0, 23'h000123, 2'b00, 8'h00, 5);

      // Boot download with a CPU request held (must wait for boot_mode=0)
      boot_mode = 1'b1;
      cpu_we = 1'b0; cpu_addr = 23'd2; cpu_req = 1'b1;
      cmd_q.delete();
      bcpu = cpu_acks;
      repeat (2) tick();
      for (int k = 0; k < 4; k++) begin
         bb[k]     = 2'($urandom_range(0, 3));
         sd_lat    = $urandom_range(1, 6);
         boot_addr = 23'(k); boot_bank = bb[k]; boot_din = 8'(8'hA0 + k);
         boot_wr   = 1'b1;
         bc[k]     = cyc;
         tick();
         boot_wr   = 1'b0;
         repeat (15) tick();
         ref_mem[{bb[k], 23'(k)}] = 8'(8'hA0 + k);
      end
      check("boot_cmd_count", 32'(cmd_q.size()), 32'd4);
      for (int k = 0; k < 4 && k < cmd_q.size(); k++) begin
         c = cmd_q[k];
         check("boot_we", 32'(c.we), 32'd1);
         check("boot_addr", 32'(c.addr), 32'(k));
         check("boot_bank", 32'(c.bank), 32'(bb[k]));
         check("boot_din", 32'(c.din), 32'(8'hA0 + k));
         check("boot_req_time", c.cyc, bc[k] + 2);
      end
      check("boot_ovf_clean", 32'(boot_ovf), 32'd0);
      check("cpu_blocked", cpu_acks - bcpu, 32'd0);
      cpu_req = 1'b0; boot_mode = 1'b0;
      tick();
      cpu_access(1'b0, 23'd2, bb[2], 8'h00, 3);

      // Boot overflow while the SDRAM is still busy
      cmd_q.delete();
      sd_lat = 8;
      boot_addr = 23'h40; boot_bank = 2'd1; boot_din = 8'h11; boot_wr = 1'b1;
      tick();
      boot_wr = 1'b0;
      tick();
      boot_addr = 23'h41; boot_din = 8'h22; boot_wr = 1'b1;
      tick();
      boot_wr = 1'b0;
      repeat (20) tick();
      check("ovf_flag", 32'(boot_ovf), 32'd1);
      check("ovf_cmd_count", 32'(cmd_q.size()), 32'd1);
      if (cmd_q.size() != 0) begin
         check("ovf_addr", 32'(cmd_q[0].addr), 32'h40);
         check("ovf_din", 32'(cmd_q[0].din), 32'h11);
      end
      ref_mem[{2'd1, 23'h40}] = 8'h11;

      // Randomised CPU traffic against the reference memory
      for (int n = 0; n < 30; n++) begin
         rwe = 1'($urandom_range(0, 1));
         ra  = 23'($urandom_range(0, 15));
         rb  = 2'($urandom_range(0, 3));
         rd  = 8'($urandom);
         lat = $urandom_range(1, 7);
         cpu_access(rwe, ra, rb, rd, lat);
         repeat ($urandom_range(0, 3)) tick();
      end

      // Watchdog abort on a read that is never acknowledged
      check("pre_timeout_err", 32'(timeout_err), 32'd0);
      cpu_access(1'b0, 23'h000777, 2'd3, 8'h00, 0);
      check("timeout_err", 32'(timeout_err), 32'd1);
      repeat (3) tick();

      // Reset in WAIT, then a stray mem_ack arrives
      cmd_q.delete();
      sd_lat = 10;
      bcpu = cpu_acks;
      cpu_we = 1'b0; cpu_addr = 23'h55; cpu_bank = 2'd0; cpu_req = 1'b1;
      repeat (3) tick();
      reset = 1'b1; cpu_req = 1'b0;
      tick();
      reset = 1'b0;
      repeat (15) tick();
      exp_cpu_dout = 8'hFF;
      check("rstw_no_ack", cpu_acks - bcpu, 32'd0);
      check("rstw_cmd_count", 32'(cmd_q.size()), 32'd1);
      check("rstw_timeout_err", 32'(timeout_err), 32'd0);
      check("rstw_boot_ovf", 32'(boot_ovf), 32'd0);
      check("rstw_cpu_dout", 32'(cpu_dout), 32'hFF);
      check("rstw_mem_addr", 32'(mem_addr), 32'd0);

      // Requests held continuously: CPU first after reset, then alternate
      // with aux when it is arbitrated; spacing is latency + 4.
      cmd_q.delete();
      lat = $urandom_range(1, 5);
      sd_lat = lat;
      bcpu = cpu_acks; baux = aux_acks;
      cpu_we = 1'b0; cpu_addr = 23'h100; cpu_bank = 2'd1; cpu_req = 1'b1;
      aux_we = 1'b0; aux_addr = 23'h200; aux_din = 8'h00; aux_req = 1'b1;
      c0 = cyc;
      for (int i = 0; i < 200 && (cpu_acks - bcpu) + (aux_acks - baux) < 4; i++) tick();
      cpu_req = 1'b0; aux_req = 1'b0;
      repeat (6) tick();
      check("hold_cmd_count", 32'(cmd_q.size()), 32'd4);
      for (int k = 0; k < 4 && k < cmd_q.size(); k++) begin
         c = cmd_q[k];
         check("hold_addr", 32'(c.addr), (AUX_EN && k[0]) ? 32'h200 : 32'h100);
         check("hold_bank", 32'(c.bank), (AUX_EN && k[0]) ? 32'd0 : 32'd1);
         if (k == 0) check("hold_first_req", c.cyc, c0 + 1);
         else        check("hold_spacing", c.cyc - cmd_q[k-1].cyc, lat + 4);
      end
      check("hold_cpu_acks", cpu_acks - bcpu, AUX_EN ? 32'd2 : 32'd4);
      check("hold_aux_acks", aux_acks - baux, AUX_EN ? 32'd2 : 32'd0);
      check("hold_cpu_dout", 32'(cpu_dout), 32'(ref_rd({2'd1, 23'h100})));
      check("hold_aux_dout", 32'(aux_dout), AUX_EN ? 32'(ref_rd({2'd0, 23'h200})) : 32'hFF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port arbiter that shares the SDRAM CPU/data command port between three requesters: the boot loader (ROM download), the Z80 memory interface, and an auxiliary DMA port (tape/expansion-ROM loader). It sits between the motherboard/download logic and the `sdram` core's oe/we/addr/bank/din/dout port. Video fetch stays on the dedicated `vram_*` port and is outside this block. The arbiter serialises one transaction at a time, holds each command stable until the SDRAM core acknowledges it, and returns read data with a one-cycle ack pulse.

## Interface
Parameters:
- TIMEOUT, default 255: max cycles in WAIT before abort; range 16..255, 8-bit counter.

Ports:
- clk_sys  in  1  system clock, 64 MHz
- reset  in  1  synchronous, active-high
- boot_mode  in  1  high while the ROM download is active; blocks CPU/aux grants
- boot_wr  in  1  one-cycle write strobe, at most one per 16 clk_sys
- boot_addr  in  23  boot write address
- boot_bank  in  2  boot write bank
- boot_din  in  8  boot write data
- cpu_req  in  1  level; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  23  address
- cpu_bank  in  2  bank
- cpu_din  in  8  write data
- cpu_dout  out  8  read data, valid with cpu_ack, held until next CPU read completes
- cpu_ack  out  1  one-cycle completion pulse
- aux_req, aux_we, aux_addr[22:0], aux_din[7:0]  in  same meaning as cpu_*; aux bank is fixed to 0
- aux_dout  out  8;  aux_ack  out  1  same meaning as cpu_*
- mem_req  out  1  one-cycle command strobe to SDRAM core
- mem_we  out  1;  mem_addr  out  23;  mem_bank  out  2;  mem_din  out  8  command fields, stable from mem_req until mem_ack
- mem_dout  in  8  SDRAM read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion from SDRAM core
- boot_ovf  out  1  sticky: boot_wr arrived while the boot buffer was full
- timeout_err  out  1  sticky: a transaction was aborted by the watchdog

## Operation
- Boot buffer: 1 entry (addr, bank, data, valid). boot_wr sets valid and captures the fields. If valid is already 1, boot_ovf is set, the new strobe is dropped, and the buffered entry is kept.
- States: IDLE, WAIT, ACK, GAP.
- IDLE: grant in priority order.
  - boot buffer valid > (boot_mode=0 only) CPU/aux round-robin.
  - Round-robin: when cpu_req and aux_req are both high, grant the requester not served last. The last-served pointer resets to aux, so the CPU wins the first tie.
  - A grant registers the mem_* fields, pulses mem_req, and enters WAIT.
  - No request: stay in IDLE.
- WAIT: the watchdog counts from 0.
  - mem_ack: capture mem_dout into the owner's dout (reads only; writes leave dout unchanged) and enter ACK.
  - Count reaches TIMEOUT: force dout to 8'hFF for reads, set timeout_err, and enter ACK.
  - A boot grant clears the buffer valid bit on entry to ACK.
- ACK: pulse the owner's ack (boot has no ack), then enter GAP.
- GAP: one cycle with no grant, so a requester that drops req on the edge after ack is not regranted. Then return to IDLE.
- mem_ack outside WAIT is ignored. This covers stray completions after reset.
- boot_mode high mid-transaction: the current transaction completes normally; later CPU/aux requests wait.

## Timing
- Reset values:
  - state IDLE, all acks/mem_req/mem_we 0
  - mem_addr/mem_bank/mem_din 0, cpu_dout/aux_dout 8'hFF
  - boot buffer empty, boot_ovf 0, timeout_err 0, pointer = aux
- Reset mid-transaction abandons the transaction with no ack.
- Request sampled high at edge N: mem_req is high for cycle N+1.
- mem_ack sampled at edge M: ack is high for cycle M+1, GAP at M+2, next grant decision at edge M+3.
- Minimum back-to-back spacing is 4 cycles plus the SDRAM latency.
- boot_wr and a grant on the same edge: the strobe is captured. If it lands on a boot entry already granted, the buffer is still full until ACK, so boot_ovf is set.

## Configuration
- MEM_ARB_AUX_EN defined: aux port arbitrated as above.
- Not defined:
  - aux_req is ignored.
  - aux_ack is constant 0 and aux_dout is constant 8'hFF.
  - The round-robin pointer logic is removed; the CPU is the only non-boot requester.

## Test plan
- Reset, then cpu_req read at addr 23'h000123 with the SDRAM model acking after 5 cycles with 8'h5A → mem_req 1 cycle after the request, cpu_dout=8'h5A with cpu_ack 1 cycle after mem_ack, no second mem_req.
- boot_mode=1, four boot_wr 16 cycles apart (addr 0..3, data A0..A3) → four mem_req writes in order with bank and data matching; boot_ovf=0.
- boot_wr twice 2 cycles apart with the SDRAM stalled → boot_ovf=1, only the first entry written.
- cpu_req and aux_req held together (MEM_ARB_AUX_EN) for 4 transactions → grants alternate CPU, aux, CPU, aux.
- SDRAM model never acks a CPU read → cpu_ack exactly TIMEOUT+2 cycles after mem_req, cpu_dout=8'hFF, timeout_err=1.
- Assert reset in WAIT, then deliver mem_ack → no ack output, state IDLE; the next cpu_req is served normally.
